// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode values, instruction field
// layout, FSM state encoding and a small decode helper.
package alu_pkg;

  localparam int  REG_AW   = 2;
  localparam int  DATA_W   = 8;
  localparam int  NUM_REGS = 4;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SHL = 1'b0;

  localparam int OPC_BIT = 7;
  localparam int RD_LO   = 5;
  localparam int RS_LO   = 3;
  localparam int RT_LO   = 1;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic              opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [2:0]        imm;
  } dec_t;

  // rt and imm overlap on purpose: add uses [2:1], shift uses [2:0]
  function automatic dec_t decode(input logic [DATA_W-1:0] w);
    dec_t d;
    d.opcode = w[OPC_BIT];
    d.rd     = w[RD_LO +: REG_AW];
    d.rs     = w[RS_LO +: REG_AW];
    d.rt     = w[RT_LO +: REG_AW];
    d.imm    = w[IMM_LO +: 3];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [NREGS];

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign ra_data  = regs_r[ra_addr];
  assign rb_data  = regs_r[rb_addr];
  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue front end for the 8-bit ALU: handshake, decode, operand read,
// latency wait and writeback, plus host load and debug read of the registers.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int NREGS       = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  instr,
  input  logic        ld_en,
  input  logic [1:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_imm,
  output logic        alu_opcode,
  input  logic [7:0]  alu_result,
  output logic        busy,
  output logic        done,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  state_t            state_r;
  logic [7:0]        instr_r;
  logic [CNT_W-1:0]  cnt_r;
  dec_t              dec_s;
  logic              we_s;
  logic [1:0]        waddr_s;
  logic [7:0]        wdata_s;
  logic [7:0]        ra_data_s;
  logic [7:0]        rb_data_s;

  assign dec_s = decode(instr_r);

  // Accept only when idle, and a host load in the same cycle takes priority
  always_comb begin
    instr_ready = 1'b0;
    if (state_r == ST_IDLE) begin
      instr_ready = ~ld_en;
    end else begin
      instr_ready = 1'b0;
    end
  end

  // Single write port shared between writeback and host load
  always_comb begin
    we_s    = 1'b0;
    waddr_s = 2'd0;
    wdata_s = 8'h00;
    if (state_r == ST_WB) begin
      we_s    = 1'b1;
      waddr_s = dec_s.rd;
      wdata_s = alu_result;
    end else if ((state_r == ST_IDLE) && ld_en) begin
      we_s    = 1'b1;
      waddr_s = ld_addr;
      wdata_s = ld_data;
    end else begin
      we_s    = 1'b0;
      waddr_s = 2'd0;
      wdata_s = 8'h00;
    end
  end

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (sysclk),
    .reset    (reset),
    .we       (we_s),
    .waddr    (waddr_s),
    .wdata    (wdata_s),
    .ra_addr  (dec_s.rt),
    .ra_data  (ra_data_s),
    .rb_addr  (dec_s.rs),
    .rb_data  (rb_data_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Issue FSM with registered ALU drive, busy and done
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      instr_r    <= 8'h00;
      cnt_r      <= '0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_imm    <= 3'd0;
      alu_opcode <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (instr_valid && instr_ready) begin
            instr_r <= instr;
            busy    <= 1'b1;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_a      <= ra_data_s;
          alu_b      <= rb_data_s;
          alu_imm    <= dec_s.imm;
          alu_opcode <= dec_s.opcode;
          cnt_r      <= CNT_W'(ALU_LATENCY - 1);
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            done    <= 1'b1;
            state_r <= ST_WB;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_WB: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
